// File: rtl/doodle_pkg.sv
// Shared types and geometry constants for the per-frame gameplay monitors.
package doodle_pkg;

  // Screen coordinate, top-left origin, y grows downward.
  typedef logic [9:0] coord_t;

  // Event monitor life cycle: waits for the first restart, then counts down
  // a grace period before positions are trusted, then latches one outcome.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRACE    = 3'd1,
    LIVE     = 3'd2,
    DROPPING = 3'd3,
    DEAD     = 3'd4
  } mon_state_t;

  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned DROP_MARGIN  = 16;
  localparam int unsigned GRACE_FRAMES = 30;
  localparam int unsigned HIT_W        = 32;
  localparam int unsigned HIT_H        = 32;
  localparam int unsigned MON_W        = 32;
  localparam int unsigned MON_H        = 32;
  localparam int unsigned STOMP_H      = 8;

  // Zero-extend a coordinate so box edges can be summed without wrapping.
  function automatic logic [10:0] ext11(input coord_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame clock into the system clock domain and turns
// each rising edge into a single-cycle registered tick.
module frame_tick_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic tick_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic tick_q;

  // Two-flop synchroniser, edge-history flop and registered edge pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      tick_q <= sync_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_event_monitor.sv
// Classifies each frame tick as drop, death or stomp from player and monster
// boxes, and holds the latched outcome until the controller restarts a round.
module game_event_monitor
  import doodle_pkg::*;
#(
  parameter int unsigned P_SCREEN_H     = SCREEN_H,
  parameter int unsigned P_DROP_MARGIN  = DROP_MARGIN,
  parameter int unsigned P_GRACE_FRAMES = GRACE_FRAMES,
  parameter int unsigned P_HIT_W        = HIT_W,
  parameter int unsigned P_HIT_H        = HIT_H,
  parameter int unsigned P_MON_W        = MON_W,
  parameter int unsigned P_MON_H        = MON_H,
  parameter int unsigned P_STOMP_H      = STOMP_H
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       restart,
  input  coord_t     player_x,
  input  coord_t     player_y,
  input  logic [9:0] player_vy,
  input  coord_t     monster_x,
  input  coord_t     monster_y,
  input  logic       monster_en,
  output logic       death,
  output logic       drop,
  output logic       stomp,
  output logic       grace_active,
  output mon_state_t dbg_state
);

  localparam logic [10:0] DROP_Y    = 11'(P_SCREEN_H + P_DROP_MARGIN);
  localparam logic [6:0]  GRACE_CNT = 7'(P_GRACE_FRAMES);

  logic tick;

  frame_tick_sync u_frame_tick_sync (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .async_i (frame_clk),
    .tick_o  (tick)
  );

  // Box edges in 11 bits so a box touching x/y=1023 does not wrap to 0.
  logic [10:0] px, py, mx, my;
  logic [10:0] p_right, p_bot, m_right, m_bot, m_stomp_bot;
  logic        overlap, stomp_cond, fell;

  assign px          = ext11(player_x);
  assign py          = ext11(player_y);
  assign mx          = ext11(monster_x);
  assign my          = ext11(monster_y);
  assign p_right     = px + 11'(P_HIT_W);
  assign p_bot       = py + 11'(P_HIT_H);
  assign m_right     = mx + 11'(P_MON_W);
  assign m_bot       = my + 11'(P_MON_H);
  assign m_stomp_bot = my + 11'(P_STOMP_H);

  assign overlap    = monster_en && (px < m_right) && (mx < p_right) &&
                      (py < m_bot) && (my < p_bot);
  // A falling player whose feet are still inside the monster's top band stomps.
  assign stomp_cond = ($signed(player_vy) > 10'sd0) && (p_bot < m_stomp_bot);
  assign fell       = (py >= DROP_Y);

  mon_state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       death_q, death_d;
  logic       drop_q, drop_d;
  logic       stomp_q, stomp_d;
  logic       grace_q;

  // Next-state and event decisions; restart overrides everything, ticks drive the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    death_d = death_q;
    drop_d  = drop_q;
    stomp_d = 1'b0;
    if (restart) begin
      state_d = GRACE;
      cnt_d   = GRACE_CNT;
      death_d = 1'b0;
      drop_d  = 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        GRACE: begin
          if (cnt_q == 7'd1) begin
            state_d = LIVE;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        LIVE: begin
          if (overlap && !stomp_cond) begin
            state_d = DEAD;
            death_d = 1'b1;
          end else if (fell) begin
            state_d = DROPPING;
            drop_d  = 1'b1;
          end else if (overlap) begin
            stomp_d = 1'b1;
          end
        end
        DROPPING: begin
          drop_d = 1'b1;
        end
        DEAD: begin
          death_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, grace counter and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      death_q <= 1'b0;
      drop_q  <= 1'b0;
      stomp_q <= 1'b0;
      grace_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      death_q <= death_d;
      drop_q  <= drop_d;
      stomp_q <= stomp_d;
      grace_q <= (state_d == GRACE);
    end
  end

  assign death        = death_q;
  assign drop         = drop_q;
  assign stomp        = stomp_q;
  assign grace_active = grace_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_game_event_monitor.sv
// Randomised scoreboard bench for game_event_monitor with a frame-level model.
module tb_game_event_monitor;
  import doodle_pkg::*;

  localparam int GRACE_N = 30;
  localparam int DROP_LIM = 496;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       restart = 1'b0;
  coord_t     player_x = '0, player_y = '0, monster_x = '0, monster_y = '0;
  logic [9:0] player_vy = '0;
  logic       monster_en = 1'b0;
  logic       death, drop, stomp, grace_active;
  mon_state_t dbg_state;

  game_event_monitor dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .restart      (restart),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_vy    (player_vy),
    .monster_x    (monster_x),
    .monster_y    (monster_y),
    .monster_en   (monster_en),
    .death        (death),
    .drop         (drop),
    .stomp        (stomp),
    .grace_active (grace_active),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_bad = 0;

  // {pre_death, pre_drop, death, drop, stomp, grace}
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: the round is "armed" after a restart; the first GRACE_N
  // ticks are only counted, later ticks are judged until an outcome latches.
  bit m_armed, m_dead, m_drop;
  int m_ticks;

  task automatic model_reset();
    m_armed = 0; m_dead = 0; m_drop = 0; m_ticks = 0;
  endtask

  task automatic model_restart();
    m_armed = 1; m_dead = 0; m_drop = 0; m_ticks = 0;
  endtask

  function automatic bit model_grace();
    return m_armed && (m_ticks < GRACE_N);
  endfunction

  task automatic model_tick(input int px, input int py, input int vy, input int mx,
                            input int my, input bit en, output logic [5:0] e);
    bit ov, sc, st;
    st = 0;
    e[5] = m_dead;
    e[4] = m_drop;
    if (m_armed) begin
      if (m_ticks < GRACE_N) begin
        m_ticks++;
      end else if (!m_dead && !m_drop) begin
        ov = en && (px < mx + 32) && (mx < px + 32) && (py < my + 32) && (my < py + 32);
        sc = (vy > 0) && (py + 32 < my + 8);
        if (ov && !sc) m_dead = 1;
        else if (py >= DROP_LIM) m_drop = 1;
        else if (ov) st = 1;
      end
    end
    e[3] = m_dead;
    e[2] = m_drop;
    e[1] = st;
    e[0] = model_grace();
  endtask

  // driver tasks
  task automatic send_frame(input int px, input int py, input int vy, input int mx,
                            input int my, input bit en);
    logic [5:0] e;
    @(negedge Clk);
    player_x = px[9:0]; player_y = py[9:0]; player_vy = vy[9:0];
    monster_x = mx[9:0]; monster_y = my[9:0]; monster_en = en;
    model_tick(px, py, vy, mx, my, en, e);
    exp_q.push_back(e);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    // Scramble inputs between ticks; they must have no effect.
    player_x = 10'($urandom); player_y = 10'($urandom); player_vy = 10'($urandom);
    monster_x = 10'($urandom); monster_y = 10'($urandom); monster_en = 1'($urandom);
    repeat (4) @(negedge Clk);
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic rand_frame();
    int px, py, mx, my, vy;
    bit en;
    px = $urandom_range(0, 1010);
    mx = clamp(px + $urandom_range(0, 80) - 40);
    if ($urandom_range(0, 7) == 0) py = $urandom_range(470, 1010);
    else py = $urandom_range(0, 470);
    my = clamp(py + $urandom_range(0, 80) - 40);
    vy = $urandom_range(0, 40) - 20;
    en = ($urandom_range(0, 3) != 0);
    send_frame(px, py, vy, mx, my, en);
  endtask

  task automatic do_restart(input int n);
    @(negedge Clk);
    restart = 1'b1;
    model_restart();
    @(posedge Clk); #1;
    check("restart_death", death, 0);
    check("restart_drop", drop, 0);
    check("restart_stomp", stomp, 0);
    check("restart_grace", grace_active, 1);
    repeat (n - 1) @(posedge Clk);
    @(negedge Clk);
    restart = 1'b0;
  endtask

  task automatic grace_frames();
    repeat (GRACE_N) rand_frame();
  endtask

  // Tick whose evaluation cycle coincides with restart: the tick is discarded.
  task automatic frame_with_restart();
    logic [5:0] e;
    @(negedge Clk);
    player_x = 10'd100; player_y = 10'd200; player_vy = 10'd0;
    monster_x = 10'd100; monster_y = 10'd200; monster_en = 1'b1;
    e[5] = m_dead; e[4] = m_drop;
    model_restart();
    e[3:0] = {1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(e);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // monitor: pops one expectation per frame_clk rising edge
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge frame_clk);
      repeat (3) @(posedge Clk); #1;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pre_death", death, e[5]);
        check("pre_drop", drop, e[4]);
        check("pre_stomp", stomp, 0);
        @(posedge Clk); #1;
        check("death", death, e[3]);
        check("drop", drop, e[2]);
        check("stomp", stomp, e[1]);
        check("grace", grace_active, e[0]);
        @(posedge Clk); #1;
        check("stomp_width", stomp, 0);
      end
    end
  end

  // main sequence
  initial begin
    model_reset();
    repeat (3) @(posedge Clk); #1;
    check("rst_death", death, 0);
    check("rst_drop", drop, 0);
    check("rst_stomp", stomp, 0);
    check("rst_grace", grace_active, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge Clk);
    Reset = 1'b0;

    // IDLE ignores ticks that would otherwise kill
    send_frame(100, 200, -3, 110, 210, 1);

    // grace period with the player far below the screen, then drop
    do_restart(2);
    repeat (GRACE_N) send_frame(100, 600, 5, 0, 0, 0);
    send_frame(100, 600, 5, 0, 0, 0);

    // restart pulse out of DROPPING, then boundary touching boxes
    do_restart(1);
    grace_frames();
    send_frame(100, 200, -3, 132, 200, 1);
    send_frame(100, 200, -3, 100, 232, 1);

    // hit -> death, held over further ticks
    send_frame(100, 200, -3, 110, 210, 1);
    repeat (10) rand_frame();

    // asynchronous reset in DEAD
    @(negedge Clk); #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("areset_death", death, 0);
    check("areset_drop", drop, 0);
    check("areset_grace", grace_active, 0);
    check("areset_state", dbg_state, IDLE);
    @(negedge Clk);
    Reset = 1'b0;
    send_frame(100, 600, -3, 110, 610, 1);

    // stomp: one pulse, stay live
    do_restart(3);
    grace_frames();
    send_frame(100, 180, 4, 100, 205, 1);
    send_frame(100, 100, -2, 400, 100, 1);

    // hit and fall on the same tick -> death only
    send_frame(100, 500, -3, 100, 490, 1);
    do_restart(1);
    grace_frames();
    send_frame(100, 500, -3, 100, 490, 0);

    // tick coinciding with restart is discarded
    frame_with_restart();
    grace_frames();

    // randomised play with occasional restarts
    for (int i = 0; i < 400; i++) begin
      if ((m_dead || m_drop || !m_armed) && ($urandom_range(0, 5) == 0)) begin
        do_restart($urandom_range(1, 3));
      end
      rand_frame();
    end

    repeat (10) @(posedge Clk); #1;
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
